// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller: merges ALU results with in-order load
// responses and keeps a scoreboard of pending load destinations for decode.
module rf_writeback_ctrl #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_we_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_wd_i,
  input  logic        ld_issue_i,
  input  logic [4:0]  ld_issue_rd_i,
  output logic        ld_issue_ready_o,
  input  logic        ld_rsp_valid_i,
  input  logic [31:0] ld_rsp_data_i,
  output logic        ld_rsp_ready_o,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic [4:0]  dec_rd_i,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(LQ_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0] CNT_ONE = (PW + 1)'(1);

  logic [4:0]          lq_rd_r   [LQ_DEPTH];
  logic [31:0]         lq_data_r [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] lq_filled_r;
  logic [PW-1:0]       hd_r;
  logic [PW-1:0]       tl_r;
  logic [PW-1:0]       fp_r;
  logic [PW:0]         count_r;
  logic [31:0]         pending_r;
  logic                rf_we_r;
  logic                rf_ld_r;
  logic [4:0]          rf_waddr_r;
  logic [31:0]         rf_wdata_r;

  logic        issue_ready_s;
  logic        rsp_ready_s;
  logic        issue_s;
  logic        rsp_s;
  logic        alu_sel_s;
  logic        pop_s;
  logic [4:0]  head_rd_s;
  logic [31:0] head_data_s;
  logic        wr_we_s;
  logic        wr_ld_s;
  logic [4:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  logic [31:0] pending_nxt_s;
  logic [PW:0] count_nxt_s;

  // When full, fp == tl is ambiguous; the fill flag at fp disambiguates.
  assign issue_ready_s = (count_r < FULL_CNT);
  assign rsp_ready_s   = (fp_r != tl_r) || ((count_r == FULL_CNT) && !lq_filled_r[fp_r]);
  assign issue_s       = ld_issue_i & issue_ready_s;
  assign rsp_s         = ld_rsp_valid_i & rsp_ready_s;
  assign alu_sel_s     = alu_we_i & (alu_rd_i != 5'd0);
  assign pop_s         = !alu_sel_s & lq_filled_r[hd_r];
  assign head_rd_s     = lq_rd_r[hd_r];
  assign head_data_s   = lq_data_r[hd_r];

  assign ld_issue_ready_o = issue_ready_s;
  assign ld_rsp_ready_o   = rsp_ready_s;
  assign stall_o          = pending_r[dec_rs1_i] | pending_r[dec_rs2_i] | pending_r[dec_rd_i];
  assign rf_we_o          = rf_we_r;
  assign rf_waddr_o       = rf_waddr_r;
  assign rf_wdata_o       = rf_wdata_r;

  // Write-port arbitration: ALU first, then a filled head entry.
  always_comb begin
    wr_we_s   = 1'b0;
    wr_ld_s   = 1'b0;
    wr_addr_s = rf_waddr_r;
    wr_data_s = rf_wdata_r;
    if (alu_sel_s) begin
      wr_we_s   = 1'b1;
      wr_addr_s = alu_rd_i;
      wr_data_s = alu_wd_i;
    end else if (pop_s && (head_rd_s != 5'd0)) begin
      wr_we_s   = 1'b1;
      wr_ld_s   = 1'b1;
      wr_addr_s = head_rd_s;
      wr_data_s = head_data_s;
    end else begin
      wr_we_s = 1'b0;
    end
  end

  // Scoreboard next state: the clear is applied first so a same-index set wins.
  always_comb begin
    pending_nxt_s = pending_r;
    if (rf_we_r && rf_ld_r) begin
      pending_nxt_s[rf_waddr_r] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (issue_s) begin
      pending_nxt_s[ld_issue_rd_i] = 1'b1;
    end else begin
      pending_nxt_s[0] = 1'b0;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Occupancy next state.
  always_comb begin
    count_nxt_s = count_r;
    case ({issue_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Queue payload storage; contents are only meaningful while their entry is live.
  always_ff @(posedge clk_i) begin
    if (issue_s) begin
      lq_rd_r[tl_r] <= ld_issue_rd_i;
    end
    if (rsp_s) begin
      lq_data_r[fp_r] <= ld_rsp_data_i;
    end
  end

  // Queue control, scoreboard and registered write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lq_filled_r <= '0;
      hd_r        <= '0;
      tl_r        <= '0;
      fp_r        <= '0;
      count_r     <= '0;
      pending_r   <= 32'd0;
      rf_we_r     <= 1'b0;
      rf_ld_r     <= 1'b0;
      rf_waddr_r  <= 5'd0;
      rf_wdata_r  <= 32'd0;
    end else begin
      if (issue_s) begin
        lq_filled_r[tl_r] <= 1'b0;
        tl_r              <= tl_r + PTR_ONE;
      end
      if (rsp_s) begin
        lq_filled_r[fp_r] <= 1'b1;
        fp_r              <= fp_r + PTR_ONE;
      end
      if (pop_s) begin
        lq_filled_r[hd_r] <= 1'b0;
        hd_r              <= hd_r + PTR_ONE;
      end
      count_r    <= count_nxt_s;
      pending_r  <= pending_nxt_s;
      rf_we_r    <= wr_we_s;
      rf_ld_r    <= wr_ld_s;
      rf_waddr_r <= wr_addr_s;
      rf_wdata_r <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_rf_writeback_ctrl;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_ni;
  logic        alu_we_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_wd_i;
  logic        ld_issue_i;
  logic [4:0]  ld_issue_rd_i;
  logic        ld_issue_ready_o;
  logic        ld_rsp_valid_i;
  logic [31:0] ld_rsp_data_i;
  logic        ld_rsp_ready_o;
  logic [4:0]  dec_rs1_i;
  logic [4:0]  dec_rs2_i;
  logic [4:0]  dec_rd_i;
  logic        stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int checks = 0;
  int errors = 0;

  rf_writeback_ctrl #(.LQ_DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .alu_we_i         (alu_we_i),
    .alu_rd_i         (alu_rd_i),
    .alu_wd_i         (alu_wd_i),
    .ld_issue_i       (ld_issue_i),
    .ld_issue_rd_i    (ld_issue_rd_i),
    .ld_issue_ready_o (ld_issue_ready_o),
    .ld_rsp_valid_i   (ld_rsp_valid_i),
    .ld_rsp_data_i    (ld_rsp_data_i),
    .ld_rsp_ready_o   (ld_rsp_ready_o),
    .dec_rs1_i        (dec_rs1_i),
    .dec_rs2_i        (dec_rs2_i),
    .dec_rd_i         (dec_rd_i),
    .stall_o          (stall_o),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending loads in issue order, first m_nf of them have data.
  logic [4:0]  m_rd  [$];
  logic [31:0] m_dat [$];
  int          m_nf = 0;
  logic [31:0] m_pend = 32'd0;
  logic        m_we = 1'b0;
  logic        m_ld = 1'b0;
  logic [4:0]  m_wa = 5'd0;
  logic [31:0] m_wd = 32'd0;
  logic        m_iss, m_rsp, m_alu, m_pop;
  logic [4:0]  m_hrd;
  logic [31:0] m_hdat;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        m_rd.delete();
        m_dat.delete();
        m_nf   = 0;
        m_pend = 32'd0;
        m_we   = 1'b0;
        m_ld   = 1'b0;
        m_wa   = 5'd0;
        m_wd   = 32'd0;
      end
      chk("model_we", {31'd0, rf_we_o}, {31'd0, m_we});
      if (m_we || !rst_ni) begin
        chk("model_waddr", {27'd0, rf_waddr_o}, {27'd0, m_wa});
        chk("model_wdata", rf_wdata_o, m_wd);
      end
      chk("model_issue_ready", {31'd0, ld_issue_ready_o}, {31'd0, (m_rd.size() < DEPTH)});
      chk("model_rsp_ready", {31'd0, ld_rsp_ready_o}, {31'd0, (m_nf < m_rd.size())});
      chk("model_stall", {31'd0, stall_o},
          {31'd0, (m_pend[dec_rs1_i] | m_pend[dec_rs2_i] | m_pend[dec_rd_i])});
      if (rst_ni) begin
        m_iss = ld_issue_i && (m_rd.size() < DEPTH);
        m_rsp = ld_rsp_valid_i && (m_nf < m_rd.size());
        m_alu = alu_we_i && (alu_rd_i != 5'd0);
        m_pop = !m_alu && (m_nf > 0);
        if (m_we && m_ld) m_pend[m_wa] = 1'b0;
        if (m_iss && (ld_issue_rd_i != 5'd0)) m_pend[ld_issue_rd_i] = 1'b1;
        m_we = 1'b0;
        m_ld = 1'b0;
        if (m_alu) begin
          m_we = 1'b1;
          m_wa = alu_rd_i;
          m_wd = alu_wd_i;
        end else if (m_pop) begin
          m_hrd  = m_rd[0];
          m_hdat = m_dat[0];
          if (m_hrd != 5'd0) begin
            m_we = 1'b1;
            m_ld = 1'b1;
            m_wa = m_hrd;
            m_wd = m_hdat;
          end
        end
        if (m_rsp) begin
          m_dat[m_nf] = ld_rsp_data_i;
          m_nf++;
        end
        if (m_pop) begin
          void'(m_rd.pop_front());
          void'(m_dat.pop_front());
          m_nf--;
        end
        if (m_iss) begin
          m_rd.push_back(ld_issue_rd_i);
          m_dat.push_back(32'd0);
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    alu_we_i = 1'b0; alu_rd_i = 5'd0; alu_wd_i = 32'd0;
    ld_issue_i = 1'b0; ld_issue_rd_i = 5'd0;
    ld_rsp_valid_i = 1'b0; ld_rsp_data_i = 32'd0;
    dec_rs1_i = 5'd0; dec_rs2_i = 5'd0; dec_rd_i = 5'd0;
    cyc();
    cyc();
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_issue_ready", {31'd0, ld_issue_ready_o}, 32'd1);
    chk("rst_rsp_ready", {31'd0, ld_rsp_ready_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    rst_ni = 1'b1;
    cyc();

    // ALU path
    alu_we_i = 1'b1; alu_rd_i = 5'd5; alu_wd_i = 32'hDEADBEEF;
    cyc();
    chk("alu_we", {31'd0, rf_we_o}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr_o}, 32'd5);
    chk("alu_wdata", rf_wdata_o, 32'hDEADBEEF);
    alu_we_i = 1'b0;
    cyc();
    chk("alu_we_once", {31'd0, rf_we_o}, 32'd0);
    alu_we_i = 1'b1; alu_rd_i = 5'd0; alu_wd_i = 32'h11111111;
    cyc();
    chk("alu_x0_we", {31'd0, rf_we_o}, 32'd0);
    alu_we_i = 1'b0;
    cyc();

    // Load RAW: issue in cycle 1, respond in cycle 4, write in 6, unstall in 7
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd7; dec_rs1_i = 5'd7;
    cyc();
    ld_issue_i = 1'b0;
    chk("raw_stall_c2", {31'd0, stall_o}, 32'd1);
    cyc();
    cyc();
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h00001234;
    cyc();
    ld_rsp_valid_i = 1'b0;
    chk("raw_we_c5", {31'd0, rf_we_o}, 32'd0);
    chk("raw_stall_c5", {31'd0, stall_o}, 32'd1);
    cyc();
    chk("raw_we_c6", {31'd0, rf_we_o}, 32'd1);
    chk("raw_waddr_c6", {27'd0, rf_waddr_o}, 32'd7);
    chk("raw_wdata_c6", rf_wdata_o, 32'h00001234);
    chk("raw_stall_c6", {31'd0, stall_o}, 32'd1);
    cyc();
    chk("raw_stall_c7", {31'd0, stall_o}, 32'd0);
    dec_rs1_i = 5'd0;

    // ALU / load conflict
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd9;
    cyc();
    ld_issue_i = 1'b0;
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h0BADF00D;
    cyc();
    ld_rsp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_we_i = 1'b1; alu_rd_i = 5'd3; alu_wd_i = 32'h300 + 32'(i);
      cyc();
      chk("conf_alu_waddr", {27'd0, rf_waddr_o}, 32'd3);
      chk("conf_alu_wdata", rf_wdata_o, 32'h300 + 32'(i));
    end
    alu_we_i = 1'b0;
    cyc();
    chk("conf_ld_we", {31'd0, rf_we_o}, 32'd1);
    chk("conf_ld_waddr", {27'd0, rf_waddr_o}, 32'd9);
    chk("conf_ld_wdata", rf_wdata_o, 32'h0BADF00D);
    cyc();

    // Full queue
    for (int i = 1; i <= 4; i++) begin
      ld_issue_i = 1'b1; ld_issue_rd_i = 5'(i);
      cyc();
    end
    ld_issue_i = 1'b0;
    chk("full_not_ready", {31'd0, ld_issue_ready_o}, 32'd0);
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd5;
    cyc();
    ld_issue_i = 1'b0;
    dec_rs1_i = 5'd5;
    #1;
    chk("full_5th_ignored", {31'd0, stall_o}, 32'd0);
    dec_rs1_i = 5'd0;
    for (int i = 0; i < 4; i++) begin
      ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'hA + 32'(i);
      cyc();
      if (i == 0) begin
        chk("full_ready_before_pop", {31'd0, ld_issue_ready_o}, 32'd0);
      end else begin
        chk("full_wr_waddr", {27'd0, rf_waddr_o}, 32'(i));
        chk("full_wr_wdata", rf_wdata_o, 32'hA + 32'(i - 1));
      end
      if (i == 1) chk("full_ready_after_pop", {31'd0, ld_issue_ready_o}, 32'd1);
    end
    ld_rsp_valid_i = 1'b0;
    cyc();
    chk("full_last_waddr", {27'd0, rf_waddr_o}, 32'd4);
    chk("full_last_wdata", rf_wdata_o, 32'hD);
    cyc();

    // Reset mid-operation
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd10;
    cyc();
    ld_issue_rd_i = 5'd11;
    cyc();
    ld_issue_i = 1'b0;
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h77;
    cyc();
    ld_rsp_valid_i = 1'b0;
    dec_rs1_i = 5'd10; dec_rs2_i = 5'd11;
    #1;
    chk("midrst_stall_before", {31'd0, stall_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_rsp_ready", {31'd0, ld_rsp_ready_o}, 32'd0);
    chk("midrst_we", {31'd0, rf_we_o}, 32'd0);
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("midrst_no_write", {31'd0, rf_we_o}, 32'd0);
    end
    dec_rs1_i = 5'd0; dec_rs2_i = 5'd0;

    // Load to x0, then loads to x8 across the pointer wrap
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd0;
    cyc();
    ld_issue_i = 1'b0;
    chk("x0_no_stall", {31'd0, stall_o}, 32'd0);
    ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'hFFFF;
    cyc();
    ld_rsp_valid_i = 1'b0;
    cyc();
    chk("x0_drop", {31'd0, rf_we_o}, 32'd0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      ld_issue_i = 1'b1; ld_issue_rd_i = 5'd8;
      cyc();
      ld_issue_i = 1'b0;
      ld_rsp_valid_i = 1'b1; ld_rsp_data_i = 32'h800 + 32'(i);
      cyc();
      ld_rsp_valid_i = 1'b0;
      cyc();
      chk("wrap_we", {31'd0, rf_we_o}, 32'd1);
      chk("wrap_waddr", {27'd0, rf_waddr_o}, 32'd8);
      chk("wrap_wdata", rf_wdata_o, 32'h800 + 32'(i));
    end
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
